// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and GF(2^8) helpers for the AES key-schedule controller.
// The S-box is computed arithmetically (inverse then affine map), so no lookup table is needed.
package aes_pkg;

  localparam int WORD_W = 32;
  localparam logic [3:0] AES128_LAST_RK = 4'd10;
  localparam logic [3:0] AES256_LAST_RK = 4'd14;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GEN,
    WAIT,
    DONE
  } ks_state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (x^127 by square-and-multiply, then one squaring).
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] b;
    r = x;
    for (int k = 0; k < 6; k++) r = gf_mul(gf_mul(r, r), x);
    b = gf_mul(r, r);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Request / status / round-key read bundle between the cipher datapath and the key-schedule controller.
interface key_schedule_ctrl_if #(
  parameter int KEY_WIDTH = 128
);
  logic                   start;
  logic                   keyLen;
  logic [2*KEY_WIDTH-1:0] key_in;
  logic                   busy;
  logic                   done;
  logic                   rk_valid;
  logic [3:0]             rk_rd_addr;
  logic [KEY_WIDTH-1:0]   rk_rd_data;

  modport master (
    output start, keyLen, key_in, rk_rd_addr,
    input  busy, done, rk_valid, rk_rd_data
  );

  modport slave (
    input  start, keyLen, key_in, rk_rd_addr,
    output busy, done, rk_valid, rk_rd_data
  );
endinterface

// File: rtl/key_schedule_ctrl_generate_key.sv
// Single registered key-expansion step: one new round key from the previous one (AES-128)
// or from the previous two (AES-256). flip selects RotWord+Rcon on top of SubWord.
module generateKey
  import aes_pkg::*;
#(
  parameter int KEY_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 validIn,
  input  logic                 key256,
  input  logic                 flip,
  input  logic [3:0]           rcon_idx,
  input  logic [KEY_WIDTH-1:0] prev_key,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 validOut,
  output logic [KEY_WIDTH-1:0] key_out
);
  localparam int NW = KEY_WIDTH / WORD_W;

  logic [WORD_W-1:0]    last_w;
  logic [WORD_W-1:0]    sel_w;
  logic [WORD_W-1:0]    sub_w;
  logic [WORD_W-1:0]    temp_w;
  logic [WORD_W-1:0]    acc_w;
  logic [KEY_WIDTH-1:0] base_key;
  logic [KEY_WIDTH-1:0] next_key;
  logic                 valid_reg;
  logic [KEY_WIDTH-1:0] key_out_reg;

  assign last_w   = key[WORD_W-1:0];
  assign sel_w    = flip ? rot_word(last_w) : last_w;
  // AES-256 XORs against the round key two steps back, AES-128 against the one just before.
  assign base_key = key256 ? prev_key : key;

  genvar gi;
  generate
    for (gi = 0; gi < WORD_W / 8; gi++) begin : g_sbox
      assign sub_w[gi*8 +: 8] = sbox(sel_w[gi*8 +: 8]);
    end
  endgenerate

  assign temp_w = flip ? (sub_w ^ {rcon_byte(rcon_idx), 24'h000000}) : sub_w;

  always_comb begin
    acc_w    = temp_w;
    next_key = '0;
    for (int k = 0; k < NW; k++) begin
      acc_w = acc_w ^ base_key[KEY_WIDTH-1-k*WORD_W -: WORD_W];
      next_key[KEY_WIDTH-1-k*WORD_W -: WORD_W] = acc_w;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg   <= 1'b0;
      key_out_reg <= '0;
    end else begin
      valid_reg <= validIn;
      if (validIn) key_out_reg <= next_key;
    end
  end

  assign validOut = valid_reg;
  assign key_out  = key_out_reg;

endmodule

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128/256 key expansion: drives generateKey one round at a time and keeps
// every round key in a flop store that the cipher datapath reads by round number.
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_WIDTH = 128,
  parameter int MAX_RK    = 15
) (
  input logic              clk,
  input logic              reset,
  key_schedule_ctrl_if.slave bus
);
  localparam logic [4:0] MAX_RK_W = 5'(MAX_RK);

  ks_state_e              state_reg;
  logic [3:0]             step_reg;
  logic                   key_len_reg;
  logic [2*KEY_WIDTH-1:0] key_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   rk_valid_reg;
  logic [KEY_WIDTH-1:0]   rk_reg [MAX_RK];
  logic [KEY_WIDTH-1:0]   rd_data_reg;

  logic [3:0]             last_rk;
  logic [3:0]             key_idx;
  logic [3:0]             prev_idx;
  logic [3:0]             rcon_idx;
  logic                   gen_valid_in;
  logic                   gen_flip;
  logic                   gen_valid_out;
  logic [KEY_WIDTH-1:0]   gen_key_out;
  logic                   addr_ok;

  always_comb begin
    last_rk      = key_len_reg ? AES256_LAST_RK : AES128_LAST_RK;
    key_idx      = step_reg - 4'd1;
    prev_idx     = key_len_reg ? (step_reg - 4'd2) : key_idx;
    gen_valid_in = (state_reg == GEN);
    // AES-256 alternates RotWord+Rcon (even steps) with plain SubWord (odd steps).
    gen_flip     = !key_len_reg || !step_reg[0];
    rcon_idx     = key_len_reg ? ({1'b0, step_reg[3:1]} - 4'd1) : key_idx;
  end

  generateKey #(
    .KEY_WIDTH(KEY_WIDTH)
  ) u_gen (
    .clk      (clk),
    .reset    (reset),
    .validIn  (gen_valid_in),
    .key256   (key_len_reg),
    .flip     (gen_flip),
    .rcon_idx (rcon_idx),
    .prev_key (rk_reg[prev_idx]),
    .key      (rk_reg[key_idx]),
    .validOut (gen_valid_out),
    .key_out  (gen_key_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      step_reg     <= 4'd0;
      key_len_reg  <= 1'b0;
      key_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      rk_valid_reg <= 1'b0;
      for (int k = 0; k < MAX_RK; k++) rk_reg[k] <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            key_len_reg  <= bus.keyLen;
            key_reg      <= bus.key_in;
            rk_valid_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= LOAD;
          end
        end
        LOAD: begin
          rk_reg[0] <= key_reg[2*KEY_WIDTH-1 -: KEY_WIDTH];
          if (key_len_reg) begin
            rk_reg[1] <= key_reg[KEY_WIDTH-1:0];
            step_reg  <= 4'd2;
          end else begin
            step_reg  <= 4'd1;
          end
          state_reg <= GEN;
        end
        GEN: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          if (gen_valid_out) begin
            rk_reg[step_reg] <= gen_key_out;
            step_reg         <= step_reg + 4'd1;
            // Status flips on the edge entering DONE so done/busy/rk_valid change together.
            if (step_reg == last_rk) begin
              state_reg    <= DONE;
              done_reg     <= 1'b1;
              busy_reg     <= 1'b0;
              rk_valid_reg <= 1'b1;
            end else begin
              state_reg <= GEN;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Rounds past the end of the latched key length read as zero, as does anything past the store.
  assign addr_ok = (bus.rk_rd_addr <= last_rk) && ({1'b0, bus.rk_rd_addr} < MAX_RK_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= addr_ok ? rk_reg[bus.rk_rd_addr] : '0;
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.rk_valid   = rk_valid_reg;
  assign bus.rk_rd_data = rd_data_reg;

endmodule
